// File: rtl/jtkcpu_pkg.sv
// Shared jtkcpu definitions: push/pull sequencer state encoding and postbyte
// register-mask bit positions.
package jtkcpu_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_PSH_DEC = 3'd1,
    ST_PSH_WR  = 3'd2,
    ST_PUL_RD  = 3'd3,
    ST_FIN     = 3'd4
  } pshpul_state_t;

  localparam int unsigned BIT_CC = 0;
  localparam int unsigned BIT_A  = 1;
  localparam int unsigned BIT_B  = 2;
  localparam int unsigned BIT_DP = 3;
  localparam int unsigned BIT_X  = 4;
  localparam int unsigned BIT_Y  = 5;
  localparam int unsigned BIT_US = 6;
  localparam int unsigned BIT_PC = 7;

  // Registers X, Y, U/S and PC are 16 bits wide and take two bus bytes.
  localparam logic [7:0] WIDE_MASK = (8'(1) << BIT_X) | (8'(1) << BIT_Y)
                                   | (8'(1) << BIT_US) | (8'(1) << BIT_PC);

  function automatic logic is_wide(input logic [7:0] onehot);
    return |(onehot & WIDE_MASK);
  endfunction

endpackage

// File: rtl/jtkcpu_pshpul_pri.sv
// Priority picker over the remaining register mask: one-hot of the highest
// set bit (push order) and of the lowest set bit (pull order).
module jtkcpu_pshpul_pri (
  input  logic [7:0] i_mask,
  output logic [7:0] o_hi,
  output logic [7:0] o_lo
);

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    o_hi = '0;
    for (int i = 0; i < 8; i++) begin
      if (i_mask[i]) o_hi = 8'(1) << i;
    end
  end

  // Two's-complement trick isolates the lowest set bit.
  assign o_lo = i_mask & (~i_mask + 8'd1);

endmodule

// File: rtl/jtkcpu_pshpul.sv
// PSH/PUL sequencer: walks the postbyte register mask, one bus byte at a time,
// pushing highest register first (low byte first) or pulling lowest first.
module jtkcpu_pshpul
  import jtkcpu_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       cen,
  input  logic       psh_start,
  input  logic       pul_start,
  input  logic [7:0] postbyte,
  input  logic       ussel_in,
  input  logic       mem_ack,
  output logic [7:0] psh_sel,
  output logic       psh_hilon,
  output logic       psh_ussel,
  output logic       pshdec,
  output logic       pul_en,
  output logic       mem_rd,
  output logic       mem_wr,
  output logic       busy,
  output logic       done
);

  pshpul_state_t r_state, w_next;
  logic [7:0]    r_rem;
  logic          r_hilon;   // 1 = second byte of a 16-bit register
  logic          r_ussel;

  logic [7:0] w_hi, w_lo, w_bit;
  logic       w_push, w_pull, w_wide, w_second, w_take, w_adv;
  logic [7:0] w_rem_after;

  jtkcpu_pshpul_pri u_pri (
    .i_mask (r_rem),
    .o_hi   (w_hi),
    .o_lo   (w_lo)
  );

  assign w_push      = (r_state == ST_PSH_DEC) || (r_state == ST_PSH_WR);
  assign w_pull      = (r_state == ST_PUL_RD);
  assign w_bit       = w_pull ? w_lo : w_hi;
  assign w_wide      = is_wide(w_bit);
  assign w_second    = w_wide && !r_hilon;
  assign w_rem_after = w_second ? r_rem : (r_rem & ~w_bit);
  assign w_take      = (r_state == ST_IDLE) && (psh_start || pul_start);
  assign w_adv       = mem_ack && ((r_state == ST_PSH_WR) || w_pull);

  always_comb begin
    w_next = r_state;
    pshdec = 1'b0;
    pul_en = 1'b0;
    mem_rd = 1'b0;
    mem_wr = 1'b0;
    done   = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (psh_start)      w_next = (postbyte == 8'd0) ? ST_FIN : ST_PSH_DEC;
        else if (pul_start) w_next = (postbyte == 8'd0) ? ST_FIN : ST_PUL_RD;
      end
      ST_PSH_DEC: begin
        pshdec = cen;
        w_next = ST_PSH_WR;
      end
      ST_PSH_WR: begin
        mem_wr = 1'b1;
        if (mem_ack) w_next = (w_rem_after != 8'd0) ? ST_PSH_DEC : ST_FIN;
      end
      ST_PUL_RD: begin
        mem_rd = 1'b1;
        if (mem_ack) begin
          pul_en = cen;
          w_next = (w_rem_after != 8'd0) ? ST_PUL_RD : ST_FIN;
        end
      end
      ST_FIN: begin
        done   = cen;
        w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments; the async reset
  // clears the FSM directly so bus requests drop the moment rst rises.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_rem   <= '0;
      r_hilon <= 1'b0;
      r_ussel <= 1'b0;
    end else if (cen) begin
      r_state <= w_next;
      if (w_take) begin
        r_rem   <= postbyte;
        r_ussel <= ussel_in;
        r_hilon <= 1'b0;
      end else if (w_adv) begin
        if (w_second) begin
          r_hilon <= 1'b1;
        end else begin
          r_hilon <= 1'b0;
          r_rem   <= w_rem_after;
        end
      end
    end
  end

  // Push sends low byte first; pull fetches the high byte first.
  assign psh_sel   = w_push ? w_hi : (w_pull ? r_rem : 8'd0);
  assign psh_hilon = w_push ? r_hilon : (w_pull ? (w_wide && !r_hilon) : 1'b0);
  assign psh_ussel = r_ussel;
  assign busy      = (r_state != ST_IDLE);

endmodule

// File: tb/tb_jtkcpu_pshpul.sv
// Scoreboard bench for jtkcpu_pshpul: directed sequences push expected bus
// events; a monitor compares each observed strobe against the queue head.
module tb_jtkcpu_pshpul;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cen = 1'b1;
  logic       psh_start = 1'b0;
  logic       pul_start = 1'b0;
  logic [7:0] postbyte = 8'd0;
  logic       ussel_in = 1'b0;
  logic       mem_ack = 1'b0;
  logic [7:0] psh_sel;
  logic       psh_hilon, psh_ussel, pshdec, pul_en, mem_rd, mem_wr, busy, done;

  jtkcpu_pshpul dut (
    .clk       (clk),
    .rst       (rst),
    .cen       (cen),
    .psh_start (psh_start),
    .pul_start (pul_start),
    .postbyte  (postbyte),
    .ussel_in  (ussel_in),
    .mem_ack   (mem_ack),
    .psh_sel   (psh_sel),
    .psh_hilon (psh_hilon),
    .psh_ussel (psh_ussel),
    .pshdec    (pshdec),
    .pul_en    (pul_en),
    .mem_rd    (mem_rd),
    .mem_wr    (mem_wr),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  localparam logic [1:0] K_DEC = 2'd0, K_WR = 2'd1, K_RD = 2'd2, K_DONE = 2'd3;

  typedef struct packed {
    logic [1:0] kind;
    logic [7:0] sel;
    logic       hilon;
    logic       ussel;
    logic [3:0] hold;
  } ev_t;

  ev_t exp_q[$];
  int  n_checks = 0;
  int  n_errors = 0;
  int  ack_dly  = 0;
  bit  cen_mode = 1'b0;
  bit  sb_en    = 1'b1;
  int  done_cnt = 0, dec_cnt = 0, rd_cycles = 0, wr_cycles = 0, bad_strobe = 0;

  task automatic check(input string name, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, got, got, exp, exp);
    end
  endtask

  task automatic expect_ev(input logic [1:0] kind, input logic [7:0] sel,
                           input logic hilon, input logic ussel, input int hold);
    ev_t e;
    e.kind = kind; e.sel = sel; e.hilon = hilon; e.ussel = ussel; e.hold = 4'(hold);
    exp_q.push_back(e);
  endtask

  // Bus responder: ack arrives ack_dly cycles after a request (or its last ack).
  initial begin
    int cnt = 0;
    forever begin
      @(posedge clk); #1;
      if ((mem_rd || mem_wr) && !rst) begin
        if (cnt >= ack_dly) begin mem_ack = 1'b1; cnt = 0; end
        else begin mem_ack = 1'b0; cnt++; end
      end else begin
        mem_ack = 1'b0; cnt = 0;
      end
    end
  end

  // Optional clock-enable stutter, changed away from sampling points.
  initial begin
    forever begin
      @(posedge clk); #2;
      cen = cen_mode ? ~cen : 1'b1;
    end
  end

  // Monitor: one event per cycle at most, compared against the queue head.
  initial begin
    int  run = 0;
    ev_t got, e;
    bit  fire;
    forever begin
      @(negedge clk);
      fire = 1'b0;
      got  = '0;
      if ((mem_rd || mem_wr) && cen) run++;
      if (mem_rd) rd_cycles++;
      if (mem_wr) wr_cycles++;
      if ((pshdec || pul_en) && !cen) bad_strobe++;
      if (pshdec) begin
        dec_cnt++;
        fire = 1'b1;
        got  = {K_DEC, psh_sel, psh_hilon, psh_ussel, 4'd0};
      end else if (mem_wr && mem_ack && cen) begin
        fire = 1'b1;
        got  = {K_WR, psh_sel, psh_hilon, psh_ussel, 4'(run)};
      end else if (pul_en) begin
        fire = 1'b1;
        got  = {K_RD, psh_sel, psh_hilon, psh_ussel, 4'(run)};
      end else if (done) begin
        done_cnt++;
        fire = 1'b1;
        got  = {K_DONE, psh_sel, psh_hilon, psh_ussel, 4'd0};
      end
      if (mem_ack && cen && (mem_rd || mem_wr)) run = 0;
      if (!(mem_rd || mem_wr)) run = 0;
      if (fire && sb_en) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_errors++;
          $display("FAIL unexpected_event: kind=%0d sel=%h hilon=%0d ussel=%0d hold=%0d, expected none",
                   got.kind, got.sel, got.hilon, got.ussel, got.hold);
        end else begin
          e = exp_q.pop_front();
          if (got !== e) begin
            n_errors++;
            $display("FAIL event: got kind=%0d sel=%h hilon=%0d ussel=%0d hold=%0d, expected kind=%0d sel=%h hilon=%0d ussel=%0d hold=%0d",
                     got.kind, got.sel, got.hilon, got.ussel, got.hold,
                     e.kind, e.sel, e.hilon, e.ussel, e.hold);
          end
        end
      end
    end
  end

  // Holds the request until an edge with cen=1 accepts it.
  task automatic start_seq(input logic psh, input logic pul,
                           input logic [7:0] pb, input logic us);
    logic taken;
    @(posedge clk); #1;
    psh_start = psh; pul_start = pul; postbyte = pb; ussel_in = us;
    do begin
      taken = cen;
      @(posedge clk);
    end while (!taken);
    #1;
    psh_start = 1'b0; pul_start = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int budget);
    bit ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk); #1;
      if (!busy) begin ok = 1'b1; break; end
    end
    check({name, "_finished"}, int'(ok), 1);
    repeat (2) @(posedge clk);
  endtask

  initial begin
    int d0, r0, w0, dn0;
    bit seen;

    // Reset state
    #3;
    check("rst_busy", int'(busy), 0);
    check("rst_bus", int'({mem_rd, mem_wr}), 0);
    check("rst_strobes", int'({pshdec, pul_en, done}), 0);
    check("rst_sel", int'(psh_sel), 0);
    check("rst_hilon_ussel", int'({psh_hilon, psh_ussel}), 0);
    #20 rst = 1'b0;
    repeat (2) @(posedge clk);

    // PSHS 0x81: PC low, PC high, CC
    ack_dly = 0;
    expect_ev(K_DEC, 8'h80, 1'b0, 1'b0, 0);
    expect_ev(K_WR,  8'h80, 1'b0, 1'b0, 1);
    expect_ev(K_DEC, 8'h80, 1'b1, 1'b0, 0);
    expect_ev(K_WR,  8'h80, 1'b1, 1'b0, 1);
    expect_ev(K_DEC, 8'h01, 1'b0, 1'b0, 0);
    expect_ev(K_WR,  8'h01, 1'b0, 1'b0, 1);
    expect_ev(K_DONE, 8'h00, 1'b0, 1'b0, 0);
    start_seq(1'b1, 1'b0, 8'h81, 1'b0);
    check("pshs81_busy", int'(busy), 1);
    wait_idle("pshs81", 100);

    // PULU 0x06: A then B, on the U stack
    expect_ev(K_RD, 8'h06, 1'b0, 1'b1, 1);
    expect_ev(K_RD, 8'h04, 1'b0, 1'b1, 1);
    expect_ev(K_DONE, 8'h00, 1'b0, 1'b1, 0);
    start_seq(1'b0, 1'b1, 8'h06, 1'b1);
    check("pulu06_ussel", int'(psh_ussel), 1);
    wait_idle("pulu06", 100);

    // Empty mask: done one cycle after start, no bus activity
    d0 = dec_cnt; r0 = rd_cycles; w0 = wr_cycles;
    expect_ev(K_DONE, 8'h00, 1'b0, 1'b0, 0);
    start_seq(1'b1, 1'b0, 8'h00, 1'b0);
    check("zero_done_now", int'(done), 1);
    @(posedge clk); #1;
    check("zero_done_gone", int'({done, busy}), 0);
    check("zero_no_bus", (dec_cnt - d0) + (rd_cycles - r0) + (wr_cycles - w0), 0);
    repeat (2) @(posedge clk);

    // PULS 0x10 with slow ack: X high byte then low byte, 4 cycles each
    ack_dly = 3;
    expect_ev(K_RD, 8'h10, 1'b1, 1'b0, 4);
    expect_ev(K_RD, 8'h10, 1'b0, 1'b0, 4);
    expect_ev(K_DONE, 8'h00, 1'b0, 1'b0, 0);
    start_seq(1'b0, 1'b1, 8'h10, 1'b0);
    wait_idle("puls10", 100);

    // Both starts together: push wins
    ack_dly = 0;
    r0 = rd_cycles;
    expect_ev(K_DEC, 8'h02, 1'b0, 1'b0, 0);
    expect_ev(K_WR,  8'h02, 1'b0, 1'b0, 1);
    expect_ev(K_DONE, 8'h00, 1'b0, 1'b0, 0);
    start_seq(1'b1, 1'b1, 8'h02, 1'b0);
    wait_idle("both02", 100);
    check("both02_no_rd", rd_cycles - r0, 0);

    // Starts while busy are ignored
    ack_dly = 3;
    expect_ev(K_DEC, 8'h01, 1'b0, 1'b0, 0);
    expect_ev(K_WR,  8'h01, 1'b0, 1'b0, 4);
    expect_ev(K_DONE, 8'h00, 1'b0, 1'b0, 0);
    start_seq(1'b1, 1'b0, 8'h01, 1'b0);
    @(posedge clk); #1;
    psh_start = 1'b1; pul_start = 1'b1; postbyte = 8'h80; ussel_in = 1'b1;
    @(posedge clk); #1;
    psh_start = 1'b0; pul_start = 1'b0;
    wait_idle("busy_ignore", 100);

    // Clock-enable stutter: same sequence, strobes only on cen cycles
    ack_dly = 0;
    cen_mode = 1'b1;
    expect_ev(K_DEC, 8'h01, 1'b0, 1'b0, 0);
    expect_ev(K_WR,  8'h01, 1'b0, 1'b0, 1);
    expect_ev(K_DONE, 8'h00, 1'b0, 1'b0, 0);
    start_seq(1'b1, 1'b0, 8'h01, 1'b0);
    wait_idle("cen_stutter", 100);
    cen_mode = 1'b0;
    repeat (2) @(posedge clk);
    check("cen_gated_strobes", bad_strobe, 0);
    check("queue_drained", exp_q.size(), 0);

    // Reset during PSH_WR of 0xFF aborts with no done
    sb_en = 1'b0;
    ack_dly = 6;
    dn0 = done_cnt;
    start_seq(1'b1, 1'b0, 8'hFF, 1'b0);
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (mem_wr) begin seen = 1'b1; break; end
    end
    check("abort_reached_wr", int'(seen), 1);
    #2 rst = 1'b1;
    #1;
    check("abort_bus_drop", int'({mem_wr, mem_rd}), 0);
    check("abort_busy", int'(busy), 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    check("abort_no_done", done_cnt - dn0, 0);
    check("abort_idle", int'({busy, mem_wr}), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

endmodule
